// File: rtl/j0x_pkg.sv
// j0x_pkg: decode constants shared by the j0x stack CPU.
// It holds the instruction-class codes, the T'-select codes and the instruction field positions.
package j0x_pkg;

    typedef enum logic [1:0] {
        CLS_JMP  = 2'b00,
        CLS_ZBR  = 2'b01,
        CLS_CALL = 2'b10,
        CLS_ALU  = 2'b11
    } insn_cls_e;

    typedef enum logic [4:0] {
        TS_T     = 5'h00,
        TS_N     = 5'h01,
        TS_ADD   = 5'h02,
        TS_AND   = 5'h03,
        TS_OR    = 5'h04,
        TS_XOR   = 5'h05,
        TS_INV   = 5'h06,
        TS_EQ    = 5'h07,
        TS_SLT   = 5'h08,
        TS_SHR   = 5'h09,
        TS_DEC   = 5'h0A,
        TS_R     = 5'h0B,
        TS_MEM   = 5'h0C,
        TS_MUL   = 5'h0D,
        TS_BSWAP = 5'h0E,
        TS_ULT   = 5'h0F,
        TS_DEPTH = 5'h10,
        TS_SHL   = 5'h11
    } tsel_e;

    localparam int BIT_LIT   = 15;
    localparam int CLS_HI    = 14;
    localparam int CLS_LO    = 13;
    localparam int BIT_R2PC  = 12;
    localparam int TSEL_HI   = 11;
    localparam int TSEL_LO   = 8;
    localparam int BIT_T2N   = 7;
    localparam int BIT_T2R   = 6;
    localparam int BIT_NWR   = 5;
    localparam int BIT_TSEL4 = 4;
    localparam int RD_HI     = 3;
    localparam int RD_LO     = 2;
    localparam int DD_HI     = 1;
    localparam int DD_LO     = 0;

    localparam logic [1:0] DELTA_NONE = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP2 = 2'b10;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    function automatic logic [4:0] tsel_of(input logic [15:0] insn);
        return {insn[BIT_TSEL4], insn[TSEL_HI:TSEL_LO]};
    endfunction

endpackage

// File: rtl/j0x_if.sv
// j0x_if: instruction-fetch and data-memory bus of the j0x core.
interface j0x_if #(
    parameter int PC_W = 7
);
    logic [PC_W-1:0] insn_addr;
    logic [15:0]     insn;
    logic            mem_rd;
    logic            mem_wr;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_dout;
    logic [15:0]     mem_din;
    logic            pause;

    modport master (
        output insn_addr, mem_rd, mem_wr, mem_addr, mem_dout,
        input  insn, mem_din, pause
    );

    modport slave (
        input  insn_addr, mem_rd, mem_wr, mem_addr, mem_dout,
        output insn, mem_din, pause
    );
endinterface

// File: rtl/j0x_stack.sv
// j0x_stack: circular-buffer stack with an occupancy counter and sticky overflow/underflow flags.
module j0x_stack
    import j0x_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        en,
    input  logic [1:0]  delta,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] top,
    output logic [7:0]  depth,
    output logic        ovf,
    output logic        unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] sp, sp_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ovf_n, unf_n;

    // The pointer always moves and wraps; only the occupancy count saturates.
    assign sp_n  = sp + AW'($signed(delta));
    assign top   = mem[sp];
    assign depth = 8'(cnt);

    always_comb begin
        cnt_n = cnt;
        ovf_n = ovf;
        unf_n = unf;
        case (delta)
            DELTA_PUSH: begin
                if (cnt == FULL) ovf_n = 1'b1;
                else             cnt_n = cnt + 1'b1;
            end
            DELTA_POP: begin
                if (cnt == '0) unf_n = 1'b1;
                else           cnt_n = cnt - 1'b1;
            end
            DELTA_POP2: begin
                if (cnt < CW'(2)) begin
                    unf_n = 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt - CW'(2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (en) begin
            sp  <= sp_n;
            cnt <= cnt_n;
            ovf <= ovf_n;
            unf <= unf_n;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (en && we) mem[sp_n] <= wdata;
    end

endmodule

// File: rtl/j0x_core.sv
// j0x_core: single-cycle 16-bit stack CPU with data and return stacks.
// Define J0X_IRQ_EN to enable the edge-triggered interrupt that injects a call to IRQ_VEC.
module j0x_core
    import j0x_pkg::*;
#(
    parameter int              PC_W       = 7,
    parameter int              DSTK_DEPTH = 16,
    parameter int              RSTK_DEPTH = 16,
    parameter logic [PC_W-1:0] IRQ_VEC    = PC_W'(1)
) (
    input  logic  sys_clk_i,
    input  logic  sys_rst_i,
    j0x_if.master bus,
    input  logic  irq_i,
    output logic  irq_ack_o,
    output logic  dstk_ovf,
    output logic  dstk_unf,
    output logic  rstk_ovf,
    output logic  rstk_unf
);
    logic [PC_W-1:0] pc, pc_n, pc_inc, ret_pc;
    logic [15:0]     t, t_n, n, r, alu_out, ir, r_wdata;
    logic [7:0]      ddepth, rdepth;
    logic [4:0]      tsel;
    logic [1:0]      d_delta, r_delta;
    logic            take, run, is_lit, is_alu, d_we, r_we;
    insn_cls_e       cls;

    assign pc_inc = pc + 1'b1;
    assign run    = ~sys_rst_i & ~bus.pause;

`ifdef J0X_IRQ_EN
    logic irq_q, pending;

    // An edge arriving in the take cycle wins over the clear, so back-to-back requests are not lost.
    always_ff @(posedge sys_clk_i) begin
        irq_q <= irq_i;
        if (sys_rst_i)            pending <= 1'b0;
        else if (irq_i && !irq_q) pending <= 1'b1;
        else if (take)            pending <= 1'b0;
    end
    assign take = pending & ~bus.pause & ~sys_rst_i;
`else
    logic unused_irq;
    assign unused_irq = irq_i;
    assign take       = 1'b0;
`endif

    assign irq_ack_o = take;

    // A taken interrupt replaces the fetched word and returns to the current pc so it re-executes.
    assign ir     = take ? {1'b0, CLS_CALL, 13'(IRQ_VEC)} : bus.insn;
    assign ret_pc = take ? pc : pc_inc;
    assign is_lit = ir[BIT_LIT];
    assign cls    = insn_cls_e'(ir[CLS_HI:CLS_LO]);
    assign is_alu = ~is_lit & (cls == CLS_ALU);
    assign tsel   = tsel_of(ir);

    always_comb begin
        alu_out = t;
        case (tsel)
            TS_T:     alu_out = t;
            TS_N:     alu_out = n;
            TS_ADD:   alu_out = t + n;
            TS_AND:   alu_out = t & n;
            TS_OR:    alu_out = t | n;
            TS_XOR:   alu_out = t ^ n;
            TS_INV:   alu_out = ~t;
            TS_EQ:    alu_out = (n == t) ? 16'hFFFF : 16'h0000;
            TS_SLT:   alu_out = ($signed(n) < $signed(t)) ? 16'hFFFF : 16'h0000;
            TS_SHR:   alu_out = n >> t[3:0];
            TS_DEC:   alu_out = t - 1'b1;
            TS_R:     alu_out = r;
            TS_MEM:   alu_out = bus.mem_din;
            TS_MUL:   alu_out = n * t;
            TS_BSWAP: alu_out = {t[7:0], t[15:8]};
            TS_ULT:   alu_out = (n < t) ? 16'hFFFF : 16'h0000;
            TS_DEPTH: alu_out = {rdepth, ddepth};
            TS_SHL:   alu_out = n << t[3:0];
            default:  alu_out = t;
        endcase
    end

    always_comb begin
        t_n     = t;
        pc_n    = pc_inc;
        d_delta = DELTA_NONE;
        r_delta = DELTA_NONE;
        d_we    = 1'b0;
        r_we    = 1'b0;
        r_wdata = t;
        if (is_lit) begin
            t_n     = {1'b0, ir[BIT_LIT-1:0]};
            d_delta = DELTA_PUSH;
            d_we    = 1'b1;
        end else begin
            case (cls)
                CLS_JMP: pc_n = ir[PC_W-1:0];
                CLS_ZBR: begin
                    t_n     = n;
                    d_delta = DELTA_POP;
                    if (t == '0) pc_n = ir[PC_W-1:0];
                end
                CLS_CALL: begin
                    r_delta = DELTA_PUSH;
                    r_we    = 1'b1;
                    r_wdata = 16'({ret_pc, 1'b0});
                    pc_n    = ir[PC_W-1:0];
                end
                CLS_ALU: begin
                    t_n     = alu_out;
                    d_delta = ir[DD_HI:DD_LO];
                    r_delta = ir[RD_HI:RD_LO];
                    d_we    = ir[BIT_T2N];
                    r_we    = ir[BIT_T2R];
                    if (ir[BIT_R2PC]) pc_n = r[PC_W:1];
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rd    = ~sys_rst_i & is_alu & (tsel == TS_MEM);
    assign bus.mem_wr    = ~sys_rst_i & is_alu & ir[BIT_NWR];
    assign bus.mem_addr  = t;
    assign bus.mem_dout  = n;
    assign bus.insn_addr = sys_rst_i ? '0 : (bus.pause ? pc : pc_n);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pc <= '0;
            t  <= '0;
        end else if (!bus.pause) begin
            pc <= pc_n;
            t  <= t_n;
        end
    end

    j0x_stack #(.DEPTH(DSTK_DEPTH)) u_dstk (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .en        (run),
        .delta     (d_delta),
        .we        (d_we),
        .wdata     (t),
        .top       (n),
        .depth     (ddepth),
        .ovf       (dstk_ovf),
        .unf       (dstk_unf)
    );

    j0x_stack #(.DEPTH(RSTK_DEPTH)) u_rstk (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .en        (run),
        .delta     (r_delta),
        .we        (r_we),
        .wdata     (r_wdata),
        .top       (r),
        .depth     (rdepth),
        .ovf       (rstk_ovf),
        .unf       (rstk_unf)
    );

endmodule

// File: doc/j0x_core.md
J0X_CORE -- requirements
Module: j0x_core

Interface
REQ-001 SHALL have parameter PC_W, default 7: program counter width in words; legal range 7..13.
REQ-002 SHALL have parameter DSTK_DEPTH, default 16: data stack entries; power of two, 4..64.
REQ-003 SHALL have parameter RSTK_DEPTH, default 16: return stack entries; power of two, 4..64.
REQ-004 SHALL have parameter IRQ_VEC, default 1: interrupt vector word address, PC_W bits.
REQ-005 sys_clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 sys_rst_i  in  1  synchronous, active-high reset.
REQ-007 insn_addr  out  PC_W  fetch address: pc while pause is high, otherwise next pc.
REQ-008 insn  in  16  instruction word at the previous insn_addr.
REQ-009 mem_rd, mem_wr  out  1 each  data read strobe and write strobe.
REQ-010 mem_addr, mem_dout  out  16 each  data address (T) and write data (N).
REQ-011 mem_din  in  16  read data, consumed in the same cycle.
REQ-012 pause  in  1  stall: holds all state; insn_addr holds pc.
REQ-013 irq_i  in  1  interrupt request, rising-edge sensitive (with J0X_IRQ_EN only).
REQ-014 irq_ack_o  out  1  one-cycle pulse when an interrupt is taken.
REQ-015 dstk_ovf, dstk_unf, rstk_ovf, rstk_unf  out  1 each  sticky stack fault flags.

Function
REQ-016 Decode: bit15=1 is literal (push {0,insn[14:0]}); [15:13]=000 jump; 001 0branch (pop, jump if T==0); 010 call (push {pc+1,0} to R); 011 ALU.
REQ-017 ALU fields: T'-select {insn[4],insn[11:8]}; insn[12] R->PC (pc=rst0[PC_W:1]); insn[7] T->N; insn[6] T->R; insn[5] mem write N->[T]; insn[1:0] and insn[3:2] are signed D and R deltas.
REQ-018 T'-codes 0x00..0x0F: T, N, T+N, T&N, T|N, T^N, ~T, N==T, signed N<T, N>>T[3:0], T-1, R, [T], N*T (low 16 bits), byte-swap T, unsigned N<T; comparisons return 0xFFFF or 0x0000.
REQ-019 New codes: 0x10 DEPTH = {rdepth[7:0], ddepth[7:0]}; 0x11 N<<T[3:0]; 0x12..0x1F return T.
REQ-020 Jump/call target is insn[PC_W-1:0]; pc increments modulo 2^PC_W.
REQ-021 mem_rd high exactly when T'-select is 0x0C; mem_wr high exactly when ALU and insn[5]; both low during reset.
REQ-022 Each stack is a circular buffer; pointer wraps modulo depth; depth counters (0..DEPTH) track occupancy.
REQ-023 Push at occupancy DEPTH sets the *_ovf flag and holds the counter at DEPTH; the data write still occurs (overwrite oldest).
REQ-024 Pop at occupancy 0 sets the *_unf flag and holds the counter at 0.
REQ-025 Flags are sticky until reset; a net delta of 0 in one instruction changes neither counter nor flags.
REQ-026 While pause is high: no state change, mem_wr and mem_rd remain combinational from insn, irq edge still latched into pending.

Reset
REQ-027 Reset SHALL clear pc, both pointers, depth counters, T, all fault flags, irq pending; irq_ack_o low.
REQ-028 While sys_rst_i is high, insn_addr SHALL be 0; reset asserted mid-instruction discards that instruction with no stack or memory write.

Configuration
REQ-029 With J0X_IRQ_EN defined: when pending is set and pause is low, the fetched insn is discarded and replaced by a call to IRQ_VEC, pushing {pc,0} so the discarded insn re-executes on return; pending clears and irq_ack_o pulses in that cycle.
REQ-030 A new irq_i edge in the take cycle re-sets pending; there is no masking.
REQ-031 Without J0X_IRQ_EN: irq_i ignored, irq_ack_o tied 0, no pending register.

Structure
REQ-032 Shared package j0x_pkg SHALL hold opcode-class constants, T'-select codes, and field bit positions.
REQ-033 One sub-module j0x_stack (parametrised depth, push/pop/delta, counter, flags) SHALL be instantiated twice.

Verification
REQ-034 Program: LIT 5, LIT 3, ALU T+N -> T=8 and ddepth=1 after 3 cycles.
REQ-035 CALL 0x20 at pc 4, then ALU R->PC with rd=-1 -> insn_addr sequence 0x20, then 5; rdepth 1 then 0.
REQ-036 17 literals with DSTK_DEPTH=16 -> dstk_ovf=1 on the 17th; DEPTH returns 0x0010; the flag survives further pops and clears only on reset.
REQ-037 ALU drop at empty data stack -> dstk_unf=1 and ddepth stays 0.
REQ-038 With J0X_IRQ_EN, IRQ_VEC=1: irq_i rise while at pc 0x10 -> irq_ack_o pulses once, insn_addr=1, R top=0x0020; a return resumes at 0x10.
REQ-039 pause held 3 cycles mid-program with mem_wr insn -> pc, T, and depths unchanged; after release execution matches an unpaused run.
